execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Execute stage of the 5-stage RISC-V pipeline, directly upstream of memory_cycle.
- Takes decoded operands and control from the D/E register and applies forwarding from the M and W stages.
- Computes the ALU result, the branch decision and target, and a multi-cycle MUL via an iterative shift-add unit that stalls the front end.
- Registers everything into the E/M pipeline register consumed by memory_cycle.

Parameters:
- DATA_WIDTH, 32, datapath width; MUL iteration count equals DATA_WIDTH.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE, MulE  in  1 each  decoded control bits.
- ALUControlE  in  3  ALU operation code.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  DATA_WIDTH  operands and PC values.
- RD_E  in  REG_ADDR_W  destination register.
- ForwardA_E, ForwardB_E  in  2  forward select: 00 = RD, 01 = ResultW, 10 = ALU_ResultM.
- ResultW  in  DATA_WIDTH  writeback result for forwarding.
- FlushE  in  1  hazard unit: squash the instruction in E.
- StallE  out  1  hold F/D/E stages; the multiply is in progress.
- PCSrcE  out  1  redirect fetch.
- PCTargetE  out  DATA_WIDTH  branch/jump target.
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered control.
- RD_M  out  REG_ADDR_W  registered destination.
- PCPlus4M, WriteDataM, ALU_ResultM  out  DATA_WIDTH  registered data.

Behaviour:
- Reset (rst=0, async): all M outputs = 0; FSM = IDLE; StallE = 0.
- Operand forwarding (combinational):
  - SrcA = fwd(ForwardA_E, RD1_E).
  - WriteData = fwd(ForwardB_E, RD2_E).
  - SrcB = ALUSrcE ? Imm_Ext_E : WriteData.
  - Forward select 11 behaves as 00.
- ALU operations: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 0/1), 110 SLL, 111 SRL (shift amount = SrcB[4:0]).
  - Arithmetic wraps modulo 2^DATA_WIDTH.
  - ZeroE = (ALU result == 0).
- Branch/jump: PCTargetE = PCE + Imm_Ext_E (wrapping); PCSrcE = (BranchE & ZeroE) | JumpE, forced to 0 while StallE = 1.
- E/M register: updates on every clock edge.
  - Bubble (RegWriteM = 0, MemWriteM = 0, ResultSrcM = 0, data fields hold don't-care/previous values) when FlushE = 1 or StallE = 1.
  - Otherwise captures the E-stage values; ALU_ResultM = MUL product when the FSM is in DONE, else the ALU result.
- MUL FSM, states IDLE, BUSY, DONE:
  - IDLE & MulE & !FlushE: latch SrcA and SrcB, clear the accumulator, cnt = 0, go to BUSY; StallE = 1 in this cycle.
  - BUSY: each cycle, if multiplier bit 0 is set add the multiplicand to the accumulator; multiplicand <<= 1, multiplier >>= 1, cnt++.
  - BUSY exit: after the cnt = DATA_WIDTH-1 step, go to DONE. StallE = 1 throughout BUSY.
  - DONE: StallE = 0; E/M captures the low DATA_WIDTH bits of the product with the MUL instruction's control; go to IDLE. MulE is not re-sampled in DONE, so there is no restart.
  - Issue at cycle t: StallE is high for t..t+DATA_WIDTH (33 cycles); the result is registered at the end of cycle t+33 and is visible in M at t+34.
  - FlushE in any state: FSM returns to IDLE and the E/M entry becomes a bubble.
  - Async reset mid-multiply: FSM returns to IDLE and the partial product is discarded.
  - Non-MUL instructions: single-cycle, no stall.
- MUL instructions must set RegWriteE = 1 and MemWriteE = 0. MemWriteE is masked to 0 for MUL instructions.

Optional Feature:
- BRANCH_EXT_EN
- Defined: adds port funct3E (in, 3). Branch condition from funct3E: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU, each comparing SrcA vs WriteData; other funct3 values give "not taken". PCSrcE = (BranchE & cond) | JumpE.
- Undefined: no funct3E port; the branch condition is ZeroE only (BEQ via SUB).

Test Plan:
- Reset: rst=0 with random inputs -> all M outputs 0, StallE=0; release -> first valid ADD of 5+7 gives ALU_ResultM=12 one cycle later.
- Forwarding: RD1_E=1, ForwardA_E=10, ALU_ResultM=0x20, ADD with Imm 4 (ALUSrcE=1) -> ALU_ResultM=0x24; ForwardA_E=01, ResultW=0x100 -> 0x104.
- Branch: BranchE=1, SUB 9-9, PCE=0x40, Imm=0x10 -> PCSrcE=1, PCTargetE=0x50; with 9-8 -> PCSrcE=0; JumpE=1 -> PCSrcE=1.
- MUL: SrcA=0xFFFFFFFF, SrcB=3, RD_E=5, issued at t -> StallE=1 for 33 cycles, M bubbles in between, then ALU_ResultM=0xFFFFFFFD, RD_M=5, RegWriteM=1.
- Flush/reset mid-MUL: FlushE=1 at cycle t+10 -> StallE=0 next cycle, no MUL result written; repeat with rst=0 at t+10 -> IDLE, outputs 0.
- BRANCH_EXT_EN: funct3E=100, SrcA=-1, WriteData=1 -> taken; funct3E=110 with the same operands -> not taken.

Source files
------------

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch resolution, iterative shift-add MUL, E/M register.
// Optional BRANCH_EXT_EN adds funct3E and full RV32 branch compares; default build uses ZeroE only.
module execute_cycle #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic                  ResultSrcE,
  input  logic                  BranchE,
  input  logic                  JumpE,
  input  logic                  ALUSrcE,
  input  logic                  MulE,
  input  logic [2:0]            ALUControlE,
  input  logic [DATA_WIDTH-1:0] RD1_E,
  input  logic [DATA_WIDTH-1:0] RD2_E,
  input  logic [DATA_WIDTH-1:0] Imm_Ext_E,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] PCPlus4E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [1:0]            ForwardA_E,
  input  logic [1:0]            ForwardB_E,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic                  FlushE,
`ifdef BRANCH_EXT_EN
  input  logic [2:0]            funct3E,
`endif
  output logic                  StallE,
  output logic                  PCSrcE,
  output logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  ResultSrcM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ALU_ResultM
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  regwrite_q, memwrite_q, resultsrc_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_WIDTH-1:0] pcplus4_q, writedata_q, alu_result_q;

  logic [DATA_WIDTH-1:0] src_a, src_b, write_data, alu_res;
  logic                  br_cond, stall, bubble;
  logic [DATA_WIDTH-1:0] alu_m_d;

  always_comb begin
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_q;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   write_data = ResultW;
      2'b10:   write_data = alu_result_q;
      default: write_data = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : write_data;
  end

  always_comb begin
    case (ALUControlE)
      3'b000:  alu_res = src_a + src_b;
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b100:  alu_res = src_a ^ src_b;
      3'b101:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110:  alu_res = src_a << src_b[4:0];
      default: alu_res = src_a >> src_b[4:0];
    endcase
  end

`ifdef BRANCH_EXT_EN
  always_comb begin
    case (funct3E)
      3'b000:  br_cond = (src_a == write_data);
      3'b001:  br_cond = (src_a != write_data);
      3'b100:  br_cond = ($signed(src_a) <  $signed(write_data));
      3'b101:  br_cond = ($signed(src_a) >= $signed(write_data));
      3'b110:  br_cond = (src_a <  write_data);
      3'b111:  br_cond = (src_a >= write_data);
      default: br_cond = 1'b0;
    endcase
  end
`else
  assign br_cond = (alu_res == '0);
`endif

  assign PCTargetE = PCE + Imm_Ext_E;
  assign PCSrcE    = ((BranchE & br_cond) | JumpE) & ~stall;
  assign StallE    = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (MulE && !FlushE) begin
          mcand_d  = src_a;
          mplier_d = src_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (FlushE) state_d = S_IDLE;
  end

  // Stall is gated by reset so a held reset never freezes the front end.
  always_comb begin
    stall   = rst & ((state_q == S_BUSY) | ((state_q == S_IDLE) & MulE & ~FlushE));
    bubble  = FlushE | stall;
    alu_m_d = (state_q == S_DONE) ? acc_q : alu_res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      resultsrc_q  <= 1'b0;
      rd_q         <= '0;
      pcplus4_q    <= '0;
      writedata_q  <= '0;
      alu_result_q <= '0;
    end else begin
      regwrite_q  <= RegWriteE & ~bubble;
      memwrite_q  <= MemWriteE & ~MulE & ~bubble;
      resultsrc_q <= ResultSrcE & ~bubble;
      if (!bubble) begin
        rd_q         <= RD_E;
        pcplus4_q    <= PCPlus4E;
        writedata_q  <= write_data;
        alu_result_q <= alu_m_d;
      end
    end
  end

  assign RegWriteM   = regwrite_q;
  assign MemWriteM   = memwrite_q;
  assign ResultSrcM  = resultsrc_q;
  assign RD_M        = rd_q;
  assign PCPlus4M    = pcplus4_q;
  assign WriteDataM  = writedata_q;
  assign ALU_ResultM = alu_result_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: expected E/M entries are queued as each instruction is driven.
module tb_execute_cycle;

  logic        clk, rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE, MulE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        FlushE;
`ifdef BRANCH_EXT_EN
  logic [2:0]  funct3E;
`endif
  logic        StallE, PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE), .MulE(MulE),
    .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .FlushE(FlushE),
`ifdef BRANCH_EXT_EN
    .funct3E(funct3E),
`endif
    .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk_data;
    logic        rw, mw, rs;
    logic [4:0]  rd;
    logic [31:0] pc4, wd, alu;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [31:0] last_alu;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic chk, input logic rw, input logic mw, input logic rs,
                          input logic [4:0] rd, input logic [31:0] pc4, input logic [31:0] wd,
                          input logic [31:0] alu);
    exp_t e;
    e.chk_data = chk; e.rw = rw; e.mw = mw; e.rs = rs;
    e.rd = rd; e.pc4 = pc4; e.wd = wd; e.alu = alu;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Advance one clock and retire the oldest expected E/M entry against the DUT.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val("RegWriteM", {31'd0, RegWriteM}, {31'd0, e.rw});
      check_val("MemWriteM", {31'd0, MemWriteM}, {31'd0, e.mw});
      check_val("ResultSrcM", {31'd0, ResultSrcM}, {31'd0, e.rs});
      if (e.chk_data) begin
        check_val("RD_M", {27'd0, RD_M}, {27'd0, e.rd});
        check_val("PCPlus4M", PCPlus4M, e.pc4);
        check_val("WriteDataM", WriteDataM, e.wd);
        check_val("ALU_ResultM", ALU_ResultM, e.alu);
      end
    end
  endtask

  task automatic clear_inputs();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; JumpE = 0;
    ALUSrcE = 0; MulE = 0; ALUControlE = 3'b000;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
    RD_E = 0; ForwardA_E = 0; ForwardB_E = 0; FlushE = 0;
`ifdef BRANCH_EXT_EN
    funct3E = 3'b000;
`endif
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rd,
                                          input logic [31:0] resw, input logic [31:0] alum);
    if (sel == 2'b01) return resw;
    if (sel == 2'b10) return alum;
    return rd;
  endfunction

  task automatic check_m_zero(input string tag);
    check_val({tag, "_rw"}, {31'd0, RegWriteM}, 32'd0);
    check_val({tag, "_mw"}, {31'd0, MemWriteM}, 32'd0);
    check_val({tag, "_rs"}, {31'd0, ResultSrcM}, 32'd0);
    check_val({tag, "_rd"}, {27'd0, RD_M}, 32'd0);
    check_val({tag, "_pc4"}, PCPlus4M, 32'd0);
    check_val({tag, "_wd"}, WriteDataM, 32'd0);
    check_val({tag, "_alu"}, ALU_ResultM, 32'd0);
    check_val({tag, "_stall"}, {31'd0, StallE}, 32'd0);
  endtask

  // Simple single-cycle ADD reg+reg with no forwarding.
  task automatic issue_add(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] pc4);
    clear_inputs();
    RegWriteE = 1; RD1_E = a; RD2_E = b; RD_E = rd; PCPlus4E = pc4;
    #1;
    check_val("add_nostall", {31'd0, StallE}, 32'd0);
    push_exp(1'b1, 1'b1, 1'b0, 1'b0, rd, pc4, b, a + b);
    cycle();
  endtask

  task automatic issue_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    clear_inputs();
    MulE = 1; RegWriteE = 1; MemWriteE = 1; RD1_E = a; RD2_E = b; RD_E = rd;
    PCPlus4E = 32'h0000_0200; JumpE = 1;
  endtask

  initial begin
    logic [31:0] a, b, imm, sa, wdv, sbv, exp_alu, resw;
    logic [2:0]  op;
    logic [1:0]  fa, fb;
    logic        asrc;

    // Reset with random inputs.
    rst = 0;
    RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 1'($urandom);
    BranchE = 1'($urandom); JumpE = 1'($urandom); ALUSrcE = 1'($urandom); MulE = 1'b1;
    ALUControlE = 3'($urandom); RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom;
    PCE = $urandom; PCPlus4E = $urandom; ResultW = $urandom; RD_E = 5'($urandom);
    ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom); FlushE = 1'b0;
`ifdef BRANCH_EXT_EN
    funct3E = 3'($urandom);
`endif
    repeat (3) @(posedge clk);
    #1;
    check_m_zero("reset");
    rst = 1;

    issue_add(32'd5, 32'd7, 5'd3, 32'h0000_0004);

    // Forwarding from M and W.
    clear_inputs();
    RegWriteE = 1; RD1_E = 32'h1C; Imm_Ext_E = 32'd4; ALUSrcE = 1; RD_E = 5'd6;
    RD2_E = 32'hAA; PCPlus4E = 32'h8;
    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h8, 32'hAA, 32'h20);
    cycle();
    RD1_E = 32'd1; ForwardA_E = 2'b10; RD_E = 5'd7; PCPlus4E = 32'hC;
    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'hC, 32'hAA, 32'h24);
    cycle();
    ForwardA_E = 2'b01; ResultW = 32'h100; RD_E = 5'd8; PCPlus4E = 32'h10;
    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h10, 32'hAA, 32'h104);
    cycle();
    ForwardA_E = 2'b11; RD1_E = 32'd1; RD_E = 5'd9;
    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h10, 32'hAA, 32'h5);
    cycle();
    clear_inputs();
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; ALUControlE = 3'b001;
    RD1_E = 32'h60; ForwardB_E = 2'b01; ResultW = 32'h55; RD2_E = 32'h1; RD_E = 5'd10;
    PCPlus4E = 32'h14;
    push_exp(1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 32'h14, 32'h55, 32'h0B);
    cycle();
    last_alu = 32'h0B;

    // Random ALU operations with random forwarding.
    for (int i = 0; i < 24; i++) begin
      clear_inputs();
      op = 3'(i % 8);
      a = $urandom; b = $urandom; imm = $urandom; resw = $urandom;
      if (i == 5) begin a = 32'h8000_0000; b = 32'd1; end
      if (i == 13) begin a = 32'd1; b = 32'h8000_0000; end
      fa = 2'($urandom); fb = 2'($urandom); asrc = 1'($urandom);
      RegWriteE = 1; ALUControlE = op; RD1_E = a; RD2_E = b; Imm_Ext_E = imm;
      ResultW = resw; ForwardA_E = fa; ForwardB_E = fb; ALUSrcE = asrc;
      RD_E = 5'(i + 1); PCPlus4E = 32'(i * 4);
      sa  = fwd_ref(fa, a, resw, last_alu);
      wdv = fwd_ref(fb, b, resw, last_alu);
      sbv = asrc ? imm : wdv;
      exp_alu = alu_ref(op, sa, sbv);
      #1;
      check_val("alu_nostall", {31'd0, StallE}, 32'd0);
      push_exp(1'b1, 1'b1, 1'b0, 1'b0, 5'(i + 1), 32'(i * 4), wdv, exp_alu);
      cycle();
      last_alu = exp_alu;
    end

    // Branch / jump resolution.
    clear_inputs();
    BranchE = 1; ALUControlE = 3'b001; RD1_E = 32'd9; RD2_E = 32'd9;
    PCE = 32'h40; Imm_Ext_E = 32'h10; PCPlus4E = 32'h44;
    #1;
    check_val("beq_taken", {31'd0, PCSrcE}, 32'd1);
    check_val("beq_target", PCTargetE, 32'h50);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h44, 32'd9, 32'd0);
    cycle();
    RD2_E = 32'd8;
    #1;
    check_val("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h44, 32'd8, 32'd1);
    cycle();
    BranchE = 0; JumpE = 1; PCE = 32'hFFFF_FFF8;
    #1;
    check_val("jump_taken", {31'd0, PCSrcE}, 32'd1);
    check_val("jump_target_wrap", PCTargetE, 32'h8);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h44, 32'd8, 32'd1);
    cycle();

    // Full MUL: 33 stall cycles of bubbles, then the product.
    issue_mul(32'hFFFF_FFFF, 32'd3, 5'd5);
    for (int i = 0; i < 33; i++) begin
      #1;
      check_val("mul_stall", {31'd0, StallE}, 32'd1);
      check_val("mul_pcsrc_masked", {31'd0, PCSrcE}, 32'd0);
      push_bubble();
      cycle();
    end
    #1;
    check_val("mul_done_stall", {31'd0, StallE}, 32'd0);
    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h200, 32'd3, 32'hFFFF_FFFD);
    cycle();
    issue_add(32'h11, 32'h22, 5'd12, 32'h204);

    // Flush in the middle of a MUL.
    issue_mul(32'd7, 32'd6, 5'd13);
    for (int i = 0; i < 10; i++) begin
      #1;
      check_val("flush_pre_stall", {31'd0, StallE}, 32'd1);
      push_bubble();
      cycle();
    end
    FlushE = 1;
    push_bubble();
    cycle();
    for (int i = 0; i < 30; i++) issue_add(32'(i * 3), 32'(i + 100), 5'(i), 32'(i * 4));

    // Async reset in the middle of a MUL.
    issue_mul(32'd9, 32'd9, 5'd14);
    for (int i = 0; i < 10; i++) begin
      #1;
      push_bubble();
      cycle();
    end
    clear_inputs();
    rst = 0;
    #1;
    check_m_zero("mul_reset");
    @(posedge clk);
    #1;
    rst = 1;
    issue_add(32'd40, 32'd2, 5'd15, 32'h300);

`ifdef BRANCH_EXT_EN
    clear_inputs();
    BranchE = 1; funct3E = 3'b100; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
    #1;
    check_val("blt_taken", {31'd0, PCSrcE}, 32'd1);
    funct3E = 3'b110;
    #1;
    check_val("bltu_not_taken", {31'd0, PCSrcE}, 32'd0);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd1, 32'd0);
    cycle();
`endif

    check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
